// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader: assembles a WIDTH-bit word from a framed bit
// stream and strobes it into a downstream holding register. Optional parity via SERIAL_LOADER_PARITY_CHECK_EN.
module serial_word_loader #(
  parameter int WIDTH     = 4,
  parameter int TIMEOUT   = 255,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             abort,
  output logic             load_en,
  output logic [WIDTH-1:0] load_data,
  output logic             busy,
  output logic             err
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [TCW-1:0] TO_LIMIT = TCW'(TIMEOUT);
  localparam bit             TO_EN    = (TIMEOUT > 0);

`ifdef SERIAL_LOADER_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, LOAD} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt, sr_shift;
  logic [BCW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [TCW-1:0]   to_cnt, to_cnt_nxt, to_inc;
  logic [WIDTH-1:0] data_nxt;
  logic             err_nxt;
  logic             timeout_hit;

  generate
    if (WIDTH == 1) begin : g_shift_one
      assign sr_shift = bit_in;
    end else if (MSB_FIRST != 0) begin : g_shift_msb
      assign sr_shift = {sr[WIDTH-2:0], bit_in};
    end else begin : g_shift_lsb
      assign sr_shift = {bit_in, sr[WIDTH-1:1]};
    end
  endgenerate

  // Idle counter saturates so TIMEOUT=0 (supervision off) never wraps.
  assign to_inc      = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;
  assign timeout_hit = TO_EN && (to_inc == TO_LIMIT);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt   = state;
    sr_nxt      = sr;
    bit_cnt_nxt = bit_cnt;
    to_cnt_nxt  = to_cnt;
    err_nxt     = err;
    data_nxt    = load_data;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SHIFT;
          sr_nxt      = '0;
          bit_cnt_nxt = '0;
          to_cnt_nxt  = '0;
          err_nxt     = 1'b0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (bit_valid) begin
          sr_nxt      = sr_shift;
          bit_cnt_nxt = bit_cnt + 1'b1;
          to_cnt_nxt  = '0;
          if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
            state_nxt = PARITY;
`else
            state_nxt = LOAD;
            data_nxt  = sr_shift;
`endif
          end
        end else begin
          to_cnt_nxt = to_inc;
          if (timeout_hit) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end
      end
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
      PARITY: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (bit_valid) begin
          to_cnt_nxt = '0;
          // Even parity: the data bits XOR the parity bit must come to zero.
          if ((^sr) == bit_in) begin
            state_nxt = LOAD;
            data_nxt  = sr;
          end else begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end else begin
          to_cnt_nxt = to_inc;
          if (timeout_hit) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end
      end
`endif
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rstn) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      err       <= 1'b0;
      load_data <= '0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      bit_cnt   <= bit_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      err       <= err_nxt;
      load_data <= data_nxt;
    end
  end

  // LOAD lasts one cycle and always returns to IDLE, so the strobe cannot repeat.
  assign load_en = (state == LOAD);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_serial_word_loader.sv
// Bench for serial_word_loader: an MSB-first and an LSB-first instance share
// one stimulus stream and are checked every cycle against a frame-level model.
module tb_serial_word_loader;

  localparam int W  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rstn, start, bit_in, bit_valid, abort;
  logic         m_load_en, m_busy, m_err, l_load_en, l_busy, l_err;
  logic [W-1:0] m_data, l_data;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  serial_word_loader #(.WIDTH(W), .TIMEOUT(TO), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rstn(rstn), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .abort(abort), .load_en(m_load_en), .load_data(m_data), .busy(m_busy), .err(m_err));

  serial_word_loader #(.WIDTH(W), .TIMEOUT(TO), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rstn(rstn), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .abort(abort), .load_en(l_load_en), .load_data(l_data), .busy(l_busy), .err(l_err));

  // Frame-level model: bit n of a frame goes straight to its final position.
  typedef struct {
    bit           in_frame;
    bit           loading;
    bit           par_wait;
    int           nbits;
    int           idle;
    logic [W-1:0] word;
    logic [W-1:0] data;
    bit           err;
  } model_t;

  model_t mdl_m, mdl_l;

  function automatic model_t step(model_t m, bit lsb_first, logic st, logic bv, logic b, logic ab);
    if (m.loading) begin
      m.loading = 1'b0;
    end else if (!m.in_frame) begin
      if (st) begin
        m.in_frame = 1'b1; m.par_wait = 1'b0; m.nbits = 0; m.idle = 0;
        m.word = '0; m.err = 1'b0;
      end
    end else if (ab) begin
      m.in_frame = 1'b0;
    end else if (bv) begin
      m.idle = 0;
      if (m.par_wait) begin
        m.in_frame = 1'b0;
        if ((^{m.word, b}) == 1'b0) begin
          m.loading = 1'b1; m.data = m.word;
        end else begin
          m.err = 1'b1;
        end
      end else begin
        if (lsb_first) m.word[m.nbits] = b;
        else           m.word[W-1-m.nbits] = b;
        m.nbits++;
        if (m.nbits == W) begin
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
          m.par_wait = 1'b1;
`else
          m.in_frame = 1'b0; m.loading = 1'b1; m.data = m.word;
`endif
        end
      end
    end else begin
      m.idle++;
      if (TO > 0 && m.idle >= TO) begin
        m.in_frame = 1'b0; m.err = 1'b1;
      end
    end
    return m;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mdl_m <= '{default: 0};
      mdl_l <= '{default: 0};
    end else begin
      mdl_m <= step(mdl_m, 1'b0, start, bit_valid, bit_in, abort);
      mdl_l <= step(mdl_l, 1'b1, start, bit_valid, bit_in, abort);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("m.load_en", 32'(m_load_en), 32'(mdl_m.loading));
      check("m.load_data", 32'(m_data), 32'(mdl_m.data));
      check("m.busy", 32'(m_busy), 32'(mdl_m.in_frame || mdl_m.loading));
      check("m.err", 32'(m_err), 32'(mdl_m.err));
      check("l.load_en", 32'(l_load_en), 32'(mdl_l.loading));
      check("l.load_data", 32'(l_data), 32'(mdl_l.data));
      check("l.busy", 32'(l_busy), 32'(mdl_l.in_frame || mdl_l.loading));
      check("l.err", 32'(l_err), 32'(mdl_l.err));
    end
  end

  // Drive one cycle of inputs, then wait until the next falling edge.
  task automatic cyc(input logic st, input logic bv, input logic b, input logic ab);
    start = st; bit_valid = bv; bit_in = b; abort = ab;
    @(negedge clk);
  endtask

  task automatic frame(input logic [W-1:0] s);
    for (int i = W - 1; i >= 0; i--) cyc(1'b0, 1'b1, s[i], 1'b0);
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
    cyc(1'b0, 1'b1, ^s, 1'b0);
`endif
  endtask

  initial begin
    rstn = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; abort = 1'b0;
    #1 rstn = 1'b0;
    @(negedge clk);
    cmp_on = 1'b1;
    check("reset load_en", 32'(m_load_en), 32'd0);
    check("reset load_data", 32'(m_data), 32'd0);
    check("reset busy", 32'(m_busy), 32'd0);
    check("reset err", 32'(m_err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic frame 1,0,1,1.
    cyc(1, 0, 0, 0);
    frame(4'b1011);
    check("t1 load_en", 32'(m_load_en), 32'd1);
    check("t1 msb word", 32'(m_data), 32'hB);
    check("t1 lsb word", 32'(l_data), 32'hD);
    cyc(0, 0, 0, 0);
    check("t1 strobe once", 32'(m_load_en), 32'd0);
    check("t1 busy drop", 32'(m_busy), 32'd0);

    // Inter-bit timeout after two bits.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    repeat (TO - 1) cyc(0, 0, 0, 0);
    check("t3 busy before limit", 32'(m_busy), 32'd1);
    check("t3 err before limit", 32'(m_err), 32'd0);
    cyc(0, 0, 0, 0);
    check("t3 err", 32'(m_err), 32'd1);
    check("t3 busy", 32'(m_busy), 32'd0);
    check("t3 no load", 32'(m_load_en), 32'd0);
    check("t3 data held", 32'(m_data), 32'hB);
    cyc(1, 0, 0, 0);
    check("t3 start clears err", 32'(m_err), 32'd0);
    check("t3 busy again", 32'(m_busy), 32'd1);

    // Abort after three bits, arriving together with a fourth bit.
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 1);
    check("t4 abort busy", 32'(m_busy), 32'd0);
    check("t4 abort no load", 32'(m_load_en), 32'd0);
    check("t4 abort data held", 32'(m_data), 32'hB);
    cyc(1, 0, 0, 0);
    frame(4'b0110);
    check("t4 msb word", 32'(m_data), 32'h6);
    check("t4 lsb word", 32'(l_data), 32'h6);
    cyc(0, 0, 0, 0);

    // Bit presented with start is dropped; gap of TO-1 idle cycles is tolerated.
    cyc(1, 1, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (TO - 1) cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    check("t2 not yet", 32'(m_load_en), 32'd0);
    check("t2 still busy", 32'(m_busy), 32'd1);
    cyc(0, 1, 1, 0);
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
    cyc(0, 1, 0, 0);
`endif
    check("t2 load_en", 32'(m_load_en), 32'd1);
    check("t2 msb word", 32'(m_data), 32'h3);
    check("t2 lsb word", 32'(l_data), 32'hC);
    cyc(0, 0, 0, 0);

    // Asynchronous reset in mid-frame.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    #2 rstn = 1'b0;
    #1;
    check("t5 async data", 32'(m_data), 32'd0);
    check("t5 async busy", 32'(m_busy), 32'd0);
    check("t5 async lsb data", 32'(l_data), 32'd0);
    @(negedge clk);
    start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; abort = 1'b0;
    rstn = 1'b1;
    cyc(1, 0, 0, 0);
    frame(4'b1111);
    check("t5 word", 32'(m_data), 32'hF);
    // Start while in LOAD is ignored; start in the first IDLE cycle is taken.
    cyc(1, 0, 0, 0);
    check("t5 start in load ignored", 32'(m_busy), 32'd0);
    cyc(1, 0, 0, 0);
    check("t5 back-to-back start", 32'(m_busy), 32'd1);
    frame(4'b1000);
    check("t5 b2b msb word", 32'(m_data), 32'h8);
    check("t5 b2b lsb word", 32'(l_data), 32'h1);
    cyc(0, 0, 0, 0);

`ifdef SERIAL_LOADER_PARITY_CHECK_EN
    // Parity good then parity bad.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0); cyc(0, 1, 0, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    check("t6 parity ok load", 32'(m_load_en), 32'd1);
    check("t6 parity ok word", 32'(m_data), 32'hB);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0); cyc(0, 1, 0, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    check("t6 parity bad err", 32'(m_err), 32'd1);
    check("t6 parity bad no load", 32'(m_load_en), 32'd0);
    check("t6 parity bad data held", 32'(m_data), 32'hB);
`endif

    repeat (3) cyc(0, 0, 0, 0);
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
